// File: rtl/mesi_isc_pkg.sv
// Shared types and constants for the MESI ISC FIFO reader and its skid buffer.
package mesi_isc_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_ACTIVE, RD_FLUSH} rd_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [SKID_CNT_W-1:0] SKID_FULL = SKID_CNT_W'(SKID_DEPTH);

endpackage

// File: rtl/mesi_isc_fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream seen by the reader.
interface mesi_isc_fifo_reader_if #(parameter int DATA_WIDTH = 32);
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_rd_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;

  modport master (input fifo_empty_i, fifo_data_i, out_ready_i,
                  output fifo_rd_o, out_valid_o, out_data_o);
  modport slave  (output fifo_empty_i, fifo_data_i, out_ready_i,
                  input fifo_rd_o, out_valid_o, out_data_o);
endinterface

// File: rtl/mesi_isc_skid_buf.sv
// Two-entry skid buffer: wrapping 1-bit head/tail pointers, push/pop/clear, head word out.
module mesi_isc_skid_buf
  import mesi_isc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clr,
  output logic [SKID_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic                                  head_q, head_d, tail_q, tail_d;
  logic [SKID_CNT_W-1:0]                 cnt_q, cnt_d;
  logic                                  do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_push = push && (cnt_q != SKID_FULL);
    do_pop  = pop && (cnt_q != '0);
    if (do_push) begin
      mem_d[tail_q] = push_data;
      tail_d        = ~tail_q;
    end
    if (do_pop) head_d = ~head_q;
    // simultaneous push and pop leaves the count alone
    cnt_d = cnt_q + SKID_CNT_W'(do_push) - SKID_CNT_W'(do_pop);
    if (clr) begin
      cnt_d  = '0;
      head_d = 1'b0;
      tail_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q  <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count     = cnt_q;
  assign head_data = mem_q[head_q];

endmodule

// File: rtl/mesi_isc_fifo_reader.sv
// Read-side master for mesi_isc_basic_fifo: pops into a skid buffer, streams out, supports flush.
// Optional pop/stall statistics counters under MESI_ISC_READER_STATS_EN.
module mesi_isc_fifo_reader
  import mesi_isc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  flush_i,
  mesi_isc_fifo_reader_if.master rif,
  output logic                  busy_o,
  output logic                  flush_done_o
`ifdef MESI_ISC_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  pop_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
`endif
);

  rd_state_t             state_q, state_d;
  logic [SKID_CNT_W-1:0] skid_cnt;
  logic                  fifo_rd, push, xfer, out_valid;

  // space is judged from the registered count only, so out_ready_i never reaches fifo_rd_o
  always_comb begin
    out_valid = (skid_cnt != '0);
    xfer      = out_valid && rif.out_ready_i;
    fifo_rd   = !rif.fifo_empty_i &&
                (((state_q == RD_ACTIVE) && (skid_cnt != SKID_FULL)) || (state_q == RD_FLUSH));
    push      = fifo_rd && (state_q == RD_ACTIVE);
    state_d   = state_q;
    if (flush_i) state_d = RD_FLUSH;
    else begin
      case (state_q)
        RD_IDLE:   if (enable_i) state_d = RD_ACTIVE;
        RD_ACTIVE: if (!enable_i) state_d = RD_IDLE;
        RD_FLUSH:  if (rif.fifo_empty_i && !fifo_rd) state_d = RD_IDLE;
        default:   state_d = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= RD_IDLE;
    else      state_q <= state_d;
  end

  mesi_isc_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rif.fifo_data_i),
    .pop       (xfer),
    .clr       (flush_i),
    .count     (skid_cnt),
    .head_data (rif.out_data_o)
  );

  assign rif.fifo_rd_o   = fifo_rd;
  assign rif.out_valid_o = out_valid;
  assign busy_o          = (state_q == RD_FLUSH);
  assign flush_done_o    = (state_q == RD_FLUSH) && (state_d == RD_IDLE);

`ifdef MESI_ISC_READER_STATS_EN
  logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    pop_cnt_d   = pop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      pop_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      if (push && (pop_cnt_q != '1)) pop_cnt_d = pop_cnt_q + 1'b1;
      if (out_valid && !rif.out_ready_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pop_cnt_q   <= pop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pop_cnt_o   = pop_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mesi_isc_fifo_reader.sv
// Bench for mesi_isc_fifo_reader with a behavioural 4-deep FIFO upstream and a
// scoreboard that expects the output stream to equal the written stream.
module tb_mesi_isc_fifo_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic busy, fdone;
`ifdef MESI_ISC_READER_STATS_EN
  logic [15:0] pop_cnt, stall_cnt;
`endif

  mesi_isc_fifo_reader_if #(.DATA_WIDTH(32)) rif ();

  always #5 clk = ~clk;

  mesi_isc_fifo_reader #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .flush_i      (flush),
    .rif          (rif),
    .busy_o       (busy),
    .flush_done_o (fdone)
`ifdef MESI_ISC_READER_STATS_EN
    ,
    .pop_cnt_o    (pop_cnt),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  // upstream FIFO model, depth 4
  logic [31:0] fmem [4];
  logic [1:0]  frp, fwp;
  int          fcnt;
  logic        f_wr = 1'b0;
  logic [31:0] f_wdata = '0;
  logic        f_underflow = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      fcnt <= 0;
      frp  <= '0;
      fwp  <= '0;
    end else begin
      if (rif.fifo_rd_o && fcnt == 0) f_underflow <= 1'b1;
      if (f_wr && fcnt < 4) begin
        fmem[fwp] <= f_wdata;
        fwp       <= fwp + 2'd1;
      end
      if (rif.fifo_rd_o && fcnt != 0) frp <= frp + 2'd1;
      fcnt <= fcnt + ((f_wr && fcnt < 4) ? 1 : 0) - ((rif.fifo_rd_o && fcnt != 0) ? 1 : 0);
    end
  end

  assign rif.fifo_empty_i = (fcnt == 0);
  assign rif.fifo_data_i  = fmem[frp];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  int          xfer_cyc_q [$];
  int          cyc = 0;
  int          rd_seen = 0;
  int          done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: protocol checks and scoreboard pops, sampled mid-cycle
  logic        prev_hold = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (rif.fifo_rd_o) begin
        rd_seen++;
        chk("rd_while_empty", {63'd0, rif.fifo_empty_i}, 64'd0);
      end
      if (fdone) done_seen++;
      if (prev_hold && !prev_flush) begin
        chk("hold_valid", {63'd0, rif.out_valid_o}, 64'd1);
        chk("hold_data", {32'd0, rif.out_data_o}, {32'd0, prev_data});
      end
      if (rif.out_valid_o && rif.out_ready_i) begin
        xfer_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h expected=none (cycle %0d)", rif.out_data_o, cyc);
        end else begin
          chk("out_data", {32'd0, rif.out_data_o}, {32'd0, exp_q.pop_front()});
        end
      end
      prev_hold  = rif.out_valid_o && !rif.out_ready_i;
      prev_data  = rif.out_data_o;
      prev_flush = flush;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    f_wr    = 1'b1;
    f_wdata = d;
    exp_q.push_back(d);
    tick();
    f_wr = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
  endtask

  logic [31:0] w0;
  int          n;

  initial begin
    rif.out_ready_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", {63'd0, rif.out_valid_o}, 64'd0);
    chk("rst_data", {32'd0, rif.out_data_o}, 64'd0);
    chk("rst_rd", {63'd0, rif.fifo_rd_o}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, fdone}, 64'd0);
    tick();
    rst = 1'b1;

`ifdef MESI_ISC_READER_STATS_EN
    chk("rst_pop_cnt", {48'd0, pop_cnt}, 64'd0);
    chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    enable = 1'b1;
    repeat (2) tick();
    wr(32'h5000_0000);
    for (int i = 0; i < 20 && !rif.out_valid_o; i++) @(negedge clk);
    chk("stats_first_valid", {63'd0, rif.out_valid_o}, 64'd1);
    repeat (3) @(posedge clk);
    #1 rif.out_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) wr(32'h5000_0000 + i);
    repeat (6) tick();
    @(negedge clk);
    chk("pop_cnt", {48'd0, pop_cnt}, 64'd5);
    chk("stall_cnt", {48'd0, stall_cnt}, 64'd3);
    tick();
    rif.out_ready_i = 1'b0;
    wr(32'h5100_0000);
    repeat (3) tick();
    do_flush();
    @(negedge clk);
    chk("flush_pop_cnt", {48'd0, pop_cnt}, 64'd0);
    chk("flush_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    repeat (4) tick();
`endif

    // in-order stream at one word per cycle
    enable = 1'b1;
    rif.out_ready_i = 1'b1;
    repeat (3) tick();
    xfer_cyc_q.delete();
    wr(32'hA1);
    wr(32'hA2);
    wr(32'hA3);
    repeat (6) tick();
    chk("t1_xfers", 64'(xfer_cyc_q.size()), 64'd3);
    if (xfer_cyc_q.size() == 3) chk("t1_rate", 64'(xfer_cyc_q[2] - xfer_cyc_q[0]), 64'd2);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // full FIFO, stalled sink: skid fills to 2 and holds word0
    enable = 1'b0;
    rif.out_ready_i = 1'b0;
    repeat (2) tick();
    w0 = $urandom;
    wr(w0);
    for (int i = 0; i < 3; i++) wr($urandom);
    rd_seen = 0;
    enable = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("t2_pops", 64'(rd_seen), 64'd2);
    chk("t2_valid", {63'd0, rif.out_valid_o}, 64'd1);
    chk("t2_head", {32'd0, rif.out_data_o}, {32'd0, w0});
    tick();
    rif.out_ready_i = 1'b1;
    repeat (10) tick();
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // disable with one buffered word
    rif.out_ready_i = 1'b0;
    wr(32'h55);
    repeat (3) tick();
    enable = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_valid", {63'd0, rif.out_valid_o}, 64'd1);
    chk("t5_data", {32'd0, rif.out_data_o}, 64'h55);
    tick();
    rif.out_ready_i = 1'b1;
    tick();
    rif.out_ready_i = 1'b0;
    rd_seen = 0;
    wr(32'h66);
    repeat (5) tick();
    @(negedge clk);
    chk("t5_no_rd", 64'(rd_seen), 64'd0);
    chk("t5_empty_out", {63'd0, rif.out_valid_o}, 64'd0);
    tick();
    enable = 1'b1;
    rif.out_ready_i = 1'b1;
    repeat (5) tick();
    chk("t5_resume_rd", 64'(rd_seen), 64'd1);
    chk("t5_drained", 64'(exp_q.size()), 64'd0);

    // flush with 3 words queued (2 in skid, 1 in FIFO)
    rif.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'hF0 + i);
    repeat (4) tick();
    enable = 1'b0;
    tick();
    done_seen = 0;
    do_flush();
    @(negedge clk);
    chk("t4_busy", {63'd0, busy}, 64'd1);
    chk("t4_valid", {63'd0, rif.out_valid_o}, 64'd0);
    for (int i = 0; i < 20 && done_seen == 0; i++) tick();
    repeat (4) tick();
    @(negedge clk);
    chk("t4_done_once", 64'(done_seen), 64'd1);
    chk("t4_busy_off", {63'd0, busy}, 64'd0);
    chk("t4_fifo_empty", {63'd0, rif.fifo_empty_i}, 64'd1);
    chk("t4_valid_off", {63'd0, rif.out_valid_o}, 64'd0);
    tick();
    rd_seen = 0;
    wr(32'h77);
    repeat (3) tick();
    chk("t4_idle_no_rd", 64'(rd_seen), 64'd0);
    enable = 1'b1;
    rif.out_ready_i = 1'b1;
    repeat (5) tick();
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // random writes against random backpressure
    n = 0;
    for (int c = 0; c < 3000 && n < 200; c++) begin
      rif.out_ready_i = 1'($urandom_range(0, 1));
      if (fcnt < 4 && $urandom_range(0, 1) == 1) begin
        f_wr    = 1'b1;
        f_wdata = $urandom;
        exp_q.push_back(f_wdata);
        n++;
      end else begin
        f_wr = 1'b0;
      end
      tick();
    end
    f_wr = 1'b0;
    rif.out_ready_i = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    chk("t3_writes", 64'(n), 64'd200);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);
    chk("t3_underflow", {63'd0, f_underflow}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
